id_scoreboard: RTL and testbench

//  Register scoreboard and issue scheduler for the ID stage. Tracks destination registers of
//  in-flight long-latency writes (loads, multi-cycle ops) that cannot be forwarded before WB.

---
 rtl/id_scoreboard.sv | 152 +++++++++++++++
 tb/tb_id_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard: per-register pending-write counters for long-latency
// results, RAW/WAW hazard stall generation, and a fence drain sequencer.
module id_scoreboard #(
  parameter int NREG   = 32,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1_addr,
  input  logic              id_rs1_used,
  input  logic [4:0]        id_rs2_addr,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd_addr,
  input  logic              id_long_lat,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd_addr,
  input  logic              wb_long_lat,
  input  logic              drain_req,
  output logic              stall,
  output logic              drain_done,
  output logic [NREG-1:0]   busy_vec,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              sb_err
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_reg;
  logic              drain_done_reg;
  logic [PERF_W-1:0] stall_cycles_reg;
  logic              sb_err_reg;

  logic [CNT_W-1:0]  cnt_reg  [NREG];
  logic [CNT_W-1:0]  cnt_next [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic [NREG-1:0]   err_vec;
  logic [NREG-1:0]   clear_next_vec;

  logic rs1_haz;
  logic rs2_haz;
  logic waw_haz;
  logic haz;
  logic issue;
  logic retire;
  logic all_clear_next;

  // Per-register next-count logic; x0 is hard-wired to an empty counter.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_x0
        assign inc_vec[gi]        = 1'b0;
        assign dec_vec[gi]        = 1'b0;
        assign err_vec[gi]        = 1'b0;
        assign cnt_next[gi]       = '0;
        assign clear_next_vec[gi] = 1'b1;
        assign busy_vec[gi]       = 1'b0;
      end else begin : g_xn
        assign inc_vec[gi] = issue  & (id_rd_addr == 5'(gi));
        assign dec_vec[gi] = retire & (wb_rd_addr == 5'(gi));
        assign err_vec[gi] = dec_vec[gi] & (cnt_reg[gi] == '0);
        assign cnt_next[gi] =
            (inc_vec[gi] && !dec_vec[gi])                        ? cnt_reg[gi] + CNT_ONE :
            (dec_vec[gi] && !inc_vec[gi] && cnt_reg[gi] != '0)   ? cnt_reg[gi] - CNT_ONE :
                                                                   cnt_reg[gi];
        assign clear_next_vec[gi] = (cnt_next[gi] == '0);
        assign busy_vec[gi]       = (cnt_reg[gi] != '0);
      end
    end
  endgenerate

  assign rs1_haz = id_rs1_used & (id_rs1_addr != 5'd0) & busy_vec[id_rs1_addr];
  assign rs2_haz = id_rs2_used & (id_rs2_addr != 5'd0) & busy_vec[id_rs2_addr];
  // A full counter cannot accept another outstanding write to the same register.
  assign waw_haz = id_long_lat & (id_rd_addr != 5'd0) & (cnt_reg[id_rd_addr] == CNT_MAX);
  assign haz     = id_valid & (rs1_haz | rs2_haz | waw_haz);

  assign stall  = haz | (state_reg == ST_DRAIN);
  assign issue  = id_valid & ~stall & id_long_lat & (id_rd_addr != 5'd0);
  assign retire = wb_valid & wb_long_lat & (wb_rd_addr != 5'd0);

  // Drain completes on the edge where the last retire empties the counters.
  assign all_clear_next = &clear_next_vec;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!reset) begin
        cnt_reg[i] <= '0;
      end else begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      drain_done_reg <= 1'b0;
    end else begin
      drain_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (drain_req && !haz) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (all_clear_next) begin
            state_reg      <= ST_DONE;
            drain_done_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_reg <= '0;
      sb_err_reg       <= 1'b0;
    end else begin
      if (stall && (stall_cycles_reg != '1)) begin
        stall_cycles_reg <= stall_cycles_reg + PERF_ONE;
      end
      if (|err_vec) begin
        sb_err_reg <= 1'b1;
      end
    end
  end

  assign drain_done   = drain_done_reg;
  assign stall_cycles = stall_cycles_reg;
  assign sb_err       = sb_err_reg;

endmodule

// File: tb/tb_id_scoreboard.sv
// Scoreboard bench for id_scoreboard: directed scenarios plus random traffic, each cycle's
// expected outputs come from an integer-array reference model and are checked by a monitor.
module tb_id_scoreboard;

  localparam int NREG   = 32;
  localparam int CNT_W  = 2;
  localparam int PERF_W = 8;
  localparam int CMAX   = 3;
  localparam int PMAX   = 255;

  localparam int M_IDLE  = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [4:0]        id_rs1_addr;
  logic              id_rs1_used;
  logic [4:0]        id_rs2_addr;
  logic              id_rs2_used;
  logic [4:0]        id_rd_addr;
  logic              id_long_lat;
  logic              wb_valid;
  logic [4:0]        wb_rd_addr;
  logic              wb_long_lat;
  logic              drain_req;
  logic              stall;
  logic              drain_done;
  logic [NREG-1:0]   busy_vec;
  logic [PERF_W-1:0] stall_cycles;
  logic              sb_err;

  always #5 clk = ~clk;

  id_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_long_lat(id_long_lat),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_long_lat(wb_long_lat),
    .drain_req(drain_req), .stall(stall), .drain_done(drain_done),
    .busy_vec(busy_vec), .stall_cycles(stall_cycles), .sb_err(sb_err)
  );

  typedef struct {
    logic        stall;
    logic        drain_done;
    logic [31:0] busy;
    int          perf;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mon_cyc = 0;

  // Reference model state
  int m_cnt [NREG];
  int m_mode;
  int m_perf;
  bit m_err;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, mon_cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", longint'(stall), longint'(e.stall));
      chk("drain_done", longint'(drain_done), longint'(e.drain_done));
      chk("busy_vec", longint'(busy_vec), longint'(e.busy));
      chk("stall_cycles", longint'(stall_cycles), longint'(e.perf));
      chk("sb_err", longint'(sb_err), longint'(e.err));
      $display("cyc %0d stall=%0b done=%0b busy=%08h perf=%0d err=%0b",
               mon_cyc, stall, drain_done, busy_vec, stall_cycles, sb_err);
      mon_cyc++;
    end
  end

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_mode = M_IDLE;
    m_perf = 0;
    m_err  = 0;
  endtask

  // One clock: push expected outputs for the current inputs, advance the model, wait the edge.
  task automatic cycle();
    exp_t e;
    bit   haz;
    bit   st;
    bit   iss;
    bit   ret;
    bit   all0;
    haz = id_valid && ((id_rs1_used && id_rs1_addr != 0 && m_cnt[id_rs1_addr] > 0) ||
                       (id_rs2_used && id_rs2_addr != 0 && m_cnt[id_rs2_addr] > 0) ||
                       (id_long_lat && id_rd_addr != 0 && m_cnt[id_rd_addr] == CMAX));
    st = haz || (m_mode == M_DRAIN);
    e.stall      = st;
    e.drain_done = (m_mode == M_DONE);
    for (int r = 0; r < NREG; r++) e.busy[r] = (m_cnt[r] > 0);
    e.perf = m_perf;
    e.err  = m_err;
    exp_q.push_back(e);
    if (!reset) begin
      model_clear();
    end else begin
      iss = id_valid && !st && id_long_lat && id_rd_addr != 0;
      ret = wb_valid && wb_long_lat && wb_rd_addr != 0;
      if (ret && m_cnt[wb_rd_addr] == 0) m_err = 1;
      if (iss) m_cnt[id_rd_addr]++;
      if (ret && m_cnt[wb_rd_addr] > 0) m_cnt[wb_rd_addr]--;
      if (st && m_perf < PMAX) m_perf++;
      all0 = 1;
      for (int r = 0; r < NREG; r++) if (m_cnt[r] != 0) all0 = 0;
      case (m_mode)
        M_IDLE:  if (drain_req && !haz) m_mode = M_DRAIN;
        M_DRAIN: if (all0) m_mode = M_DONE;
        default: m_mode = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit ll);
    id_valid    = v;
    id_rs1_addr = 5'(rs1);
    id_rs1_used = u1;
    id_rs2_addr = 5'(rs2);
    id_rs2_used = u2;
    id_rd_addr  = 5'(rd);
    id_long_lat = ll;
  endtask

  task automatic set_wb(input bit v, input int rd, input bit ll);
    wb_valid    = v;
    wb_rd_addr  = 5'(rd);
    wb_long_lat = ll;
  endtask

  task automatic issue_one(input int rd);
    set_id(1, 0, 0, 0, 0, rd, 1);
    cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic retire_one(input int rd);
    set_wb(1, rd, 1);
    cycle();
    set_wb(0, 0, 0);
  endtask

  // Hold the fence until the drain_done cycle; retire r1 at c1 and r2 at c2 (fence-relative).
  task automatic fence(input int r1, input int c1, input int r2, input int c2, input int bound);
    bit was_done;
    drain_req = 1;
    for (int c = 0; c < bound; c++) begin
      set_wb(0, 0, 0);
      if (c == c1) set_wb(1, r1, 1);
      if (c == c2) set_wb(1, r2, 1);
      was_done = (m_mode == M_DONE);
      cycle();
      if (was_done) break;
    end
    drain_req = 0;
    set_wb(0, 0, 0);
  endtask

  initial begin
    bit was_done;
    int r;
    reset = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    drain_req = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    cycle();

    // Load to x5, dependent read stalls until the cycle after the retire
    issue_one(5);
    set_id(1, 5, 1, 0, 0, 6, 0);
    cycle();
    cycle();
    set_wb(1, 5, 1);
    cycle();
    set_wb(0, 0, 0);
    cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);

    // Three writes to x7 fill its counter; the fourth waits for one retire
    set_id(1, 0, 0, 0, 0, 7, 1);
    repeat (4) cycle();
    set_wb(1, 7, 1);
    cycle();
    set_wb(0, 0, 0);
    cycle();
    set_id(1, 0, 0, 0, 0, 7, 1);
    cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (3) retire_one(7);

    // Simultaneous issue and retire to x9
    issue_one(9);
    set_id(1, 0, 0, 0, 0, 9, 1);
    set_wb(1, 9, 1);
    cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    cycle();
    retire_one(9);
    cycle();

    // Fence with two pending writes retiring at fence cycles 3 and 6
    issue_one(10);
    issue_one(11);
    fence(10, 3, 11, 6, 20);
    cycle();

    // Fence with nothing pending still takes a drain cycle
    fence(0, -1, 0, -1, 10);
    cycle();

    // Spurious retire sets the sticky error; x0 reads and writes never stall
    retire_one(4);
    set_id(1, 0, 1, 0, 1, 0, 1);
    cycle();
    cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Reset in the middle of a drain
    issue_one(12);
    issue_one(13);
    drain_req = 1;
    repeat (3) cycle();
    reset = 0;
    drain_req = 0;
    cycle();
    reset = 1;
    repeat (3) cycle();

    // Long drain saturates the stall counter
    issue_one(14);
    fence(14, 300, 0, -1, 320);
    cycle();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1));
      r = $urandom_range(1, 7);
      set_wb(($urandom_range(0, 2) == 0) && (m_cnt[r] > 0 || $urandom_range(0, 60) == 0),
             r, $urandom_range(0, 9) != 0);
      if (!drain_req && m_mode == M_IDLE && $urandom_range(0, 30) == 0) drain_req = 1;
      reset = ($urandom_range(0, 500) != 0);
      was_done = (m_mode == M_DONE);
      cycle();
      if (was_done || !reset) drain_req = 0;
      reset = 1;
    end

    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    drain_req = 0;
    cycle();
    cycle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
